// File: rtl/sinal_magnitude_fifo_if.sv
// Handshake bundle between the subtractor, the sign-magnitude FIFO and its consumer.
interface sinal_magnitude_fifo_if #(
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [8:0]    in_s;
  logic          out_valid;
  logic          out_ready;
  logic          out_neg;
  logic [7:0]    out_mag;
  logic          out_zero;
  logic [CW-1:0] underflow_count;

  // Producer/consumer side: drives the input data and the consumer's ready.
  modport master (
    output in_valid, in_s, out_ready,
    input  in_ready, out_valid, out_neg, out_mag, out_zero, underflow_count
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_s, out_ready,
    output in_ready, out_valid, out_neg, out_mag, out_zero, underflow_count
  );
endinterface

// File: rtl/sinal_magnitude_fifo.sv
// Converts 9-bit two's-complement differences to sign-magnitude, buffers them
// in a DEPTH-entry FIFO and counts (saturating) the negative results accepted.
module sinal_magnitude_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  sinal_magnitude_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  // Each entry holds {neg, mag}; zero is derived from the stored magnitude.
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] ucnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          in_neg;
  logic [7:0]    in_mag;
  logic [8:0]    head;

  // Input-side conversion to sign-magnitude and handshake qualification.
  always_comb begin
    in_neg = bus.in_s[8];
    in_mag = in_neg ? (~bus.in_s[7:0] + 8'd1) : bus.in_s[7:0];
    full   = (count == (PW+1)'(DEPTH));
    empty  = (count == '0);
    push   = bus.in_valid && !full;
    pop    = !empty && bus.out_ready;
  end

  // Storage, pointers, occupancy and the saturating underflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ucnt   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_neg, in_mag};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && in_neg && (ucnt != '1)) begin
        ucnt <= ucnt + 1'b1;
      end
    end
  end

  // Head presentation; outputs are forced to 0 while the FIFO is empty.
  always_comb begin
    head                = empty ? '0 : mem[rd_ptr];
    bus.in_ready        = !full;
    bus.out_valid       = !empty;
    bus.out_neg         = head[8];
    bus.out_mag         = head[7:0];
    bus.out_zero        = !empty && (head[7:0] == 8'd0);
    bus.underflow_count = ucnt;
  end
endmodule

// File: tb/tb_sinal_magnitude_fifo.sv
// Directed bench for sinal_magnitude_fifo with a queue-based scoreboard.
module tb_sinal_magnitude_fifo;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic       neg;
    logic [7:0] mag;
    logic       zero;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  int   ucnt_model;

  always #5 clk = ~clk;

  sinal_magnitude_fifo_if #(.CW(8)) bus ();
  sinal_magnitude_fifo_if #(.CW(2)) bus2 ();

  sinal_magnitude_fifo #(.DEPTH(DEPTH), .CW(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  sinal_magnitude_fifo #(.DEPTH(DEPTH), .CW(2)) dut2 (
    .clk(clk),
    .rst(rst2),
    .bus(bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference conversion computed arithmetically from the signed value.
  function automatic ent_t conv(input logic [8:0] s);
    ent_t e;
    int   v;
    v     = s[8] ? int'(s) - 512 : int'(s);
    e.neg = (v < 0);
    e.mag = 8'((v < 0) ? -v : v);
    e.zero = (v == 0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the CW=8 instance: inputs are stable here, so this cycle's
  // push/pop decisions are predicted from the model's own occupancy.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      ucnt_model = 0;
    end else begin
      automatic bit   full  = (q.size() == DEPTH);
      automatic bit   empty = (q.size() == 0);
      automatic ent_t e;
      chk("in_ready", 32'(bus.in_ready), 32'(!full));
      chk("out_valid", 32'(bus.out_valid), 32'(!empty));
      chk("underflow_count", 32'(bus.underflow_count), 32'(ucnt_model));
      if (empty) begin
        chk("empty_out_fields", 32'({bus.out_neg, bus.out_mag, bus.out_zero}), 32'd0);
      end else if (bus.out_ready) begin
        e = q.pop_front();
        chk("pop_neg", 32'(bus.out_neg), 32'(e.neg));
        chk("pop_mag", 32'(bus.out_mag), 32'(e.mag));
        chk("pop_zero", 32'(bus.out_zero), 32'(e.zero));
      end
      if (bus.in_valid && !full) begin
        e = conv(bus.in_s);
        q.push_back(e);
        if (e.neg && ucnt_model < 255) ucnt_model++;
      end
    end
  end

  initial begin
    logic [8:0] vec4 [4];
    logic [8:0] full4 [4];
    vec4  = '{9'h000, 9'h02B, 9'h1FF, 9'h07F};
    full4 = '{9'h005, 9'h1FB, 9'h0FF, 9'h010};

    rst = 1'b1;
    rst2 = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_s = '0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_s = '0;
    bus2.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    rst2 = 1'b0;

    // Idle state straight after reset.
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_mag", 32'(bus.out_mag), 32'd0);
    chk("rst_out_neg", 32'(bus.out_neg), 32'd0);
    chk("rst_underflow", 32'(bus.underflow_count), 32'd0);

    // Fill with the four subtractor vectors, consumer stalled.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_s = vec4[i];
      tick();
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("head_zero", 32'(bus.out_zero), 32'd1);
    tick();
    chk("head_hold_mag", 32'(bus.out_mag), 32'd0);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    chk("underflow_after_4", 32'(bus.underflow_count), 32'd1);

    // Large negative magnitudes.
    bus.in_valid = 1'b1;
    bus.in_s = 9'h181;
    tick();
    bus.in_s = 9'h101;
    tick();
    bus.in_valid = 1'b0;
    chk("head_mag_127", 32'(bus.out_mag), 32'd127);
    chk("head_neg_127", 32'(bus.out_neg), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("head_mag_255", 32'(bus.out_mag), 32'd255);
    tick();
    bus.out_ready = 1'b0;
    chk("underflow_after_6", 32'(bus.underflow_count), 32'd3);

    // FULL with a held fifth entry; a pop frees space only for the next cycle.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_s = full4[i];
      tick();
    end
    bus.in_s = 9'h1F0;
    tick();
    chk("full_drop_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("refull_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("fifth_last_mag", 32'(bus.out_mag), 32'd16);
    chk("fifth_last_neg", 32'(bus.out_neg), 32'd1);
    tick();
    chk("drained", 32'(bus.out_valid), 32'd0);

    // Streaming: one in, one out every cycle.
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_s = (i % 2 == 1) ? 9'h1FF : 9'h001;
      tick();
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      chk("stream_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("stream_empty", 32'(bus.out_valid), 32'd0);
    chk("stream_underflow", 32'(bus.underflow_count), 32'd15);
    chk("model_empty", 32'(q.size()), 32'd0);

    // CW=2 instance: saturation, then reset with entries queued.
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_s = 9'h1FF;
      tick();
      chk("sat_count", 32'(bus2.underflow_count), 32'((i + 1 < 3) ? i + 1 : 3));
    end
    bus2.in_valid = 1'b0;
    tick();
    bus2.out_ready = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.in_s = 9'h1FE;
    tick();
    bus2.in_s = 9'h002;
    tick();
    chk("pre_rst_valid", 32'(bus2.out_valid), 32'd1);
    chk("pre_rst_mag", 32'(bus2.out_mag), 32'd2);
    rst2 = 1'b1;
    bus2.in_s = 9'h1F0;
    bus2.out_ready = 1'b1;
    tick();
    rst2 = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;
    chk("mid_rst_valid", 32'(bus2.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus2.in_ready), 32'd1);
    chk("mid_rst_underflow", 32'(bus2.underflow_count), 32'd0);
    chk("mid_rst_mag", 32'(bus2.out_mag), 32'd0);
    tick();
    chk("post_rst_valid", 32'(bus2.out_valid), 32'd0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sinal_magnitude_fifo.md
Name: sinal_magnitude_fifo

Overview:
- Downstream stage of the 8-bit subtractor. Consumes its 9-bit two's-complement difference S = A - B, where S[8] set means A < B.
- Converts each difference to sign-magnitude form and buffers the results in a small FIFO.
- Presents results to the consumer over a valid/ready handshake.
- Keeps a saturating count of negative results (underflow events) for status readout.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CW, 8, width of the underflow counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_s holds a difference to accept.
- in_ready  output  1  stage can accept; equals !full.
- in_s  input  9  two's-complement difference from the subtractor.
- out_valid  output  1  head entry is valid; equals !empty.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_neg  output  1  sign of the head entry (1 = negative).
- out_mag  output  8  magnitude of the head entry, 0..255.
- out_zero  output  1  head entry magnitude is 0.
- underflow_count  output  CW  number of accepted negative differences, saturating.

Behaviour:
- Reset, applied at any clk edge while rst=1, including mid-transfer:
  - FIFO empties; read pointer, write pointer and occupancy go to 0.
  - out_valid=0, in_ready=1, out_neg=0, out_mag=0, out_zero=0, underflow_count=0.
  - Handshakes during the rst cycle are ignored; nothing is stored or popped.
- Push: occurs on an edge where in_valid && in_ready. The converted entry is written at the write pointer.
- Pop: occurs on an edge where out_valid && out_ready. The read pointer advances.
- Conversion (combinational, at the input, before storage):
  - neg = in_s[8].
  - mag = neg ? low 8 bits of (~in_s + 1) : in_s[7:0].
  - zero = (mag == 0).
  - The input range is -255..+255, so mag always fits in 8 bits.
  - Examples: 9'h1FF -> neg=1, mag=1. 9'h181 -> neg=1, mag=127. 9'h101 -> neg=1, mag=255.
- Latency: an entry pushed at edge N appears on out_* with out_valid=1 from edge N onward; visible one cycle after in_valid is sampled. There is no combinational path from in_* to out_*.
- Output stability:
  - While out_valid=1 and out_ready=0, out_neg, out_mag and out_zero hold stable.
  - When empty, out_neg, out_mag and out_zero are driven 0.
- Occupancy states:
  - EMPTY (count=0): out_valid=0; pop is impossible.
  - PARTIAL (0<count<DEPTH): push and pop may coincide; on a simultaneous push+pop, count is unchanged and FIFO order is kept.
  - FULL (count=DEPTH): in_ready=0 and in_valid is ignored. A pop in the FULL cycle does not allow a same-cycle push; in_ready rises the cycle after the pop.
  - EMPTY with in_valid=1 and out_ready=1: push only, no bypass; count becomes 1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- underflow_count:
  - Increments by 1 on each push with neg=1, evaluated at the input side.
  - Holds at 2^CW-1 once reached; never wraps.
  - Unaffected by pops.
- No other outputs change on cycles with no push or pop.

Test Plan:
- Reset, then check idle outputs: out_valid=0, in_ready=1, out_mag=0, out_neg=0, underflow_count=0.
- Push the subtractor vectors in order: 9'h000 (0-0), 9'h02B (85-42), 9'h1FF (0-1), 9'h07F (255-128). Hold out_ready=0.
  - in_ready drops after the 4th push.
  - Then set out_ready=1 and read (neg,mag,zero) = (0,0,1), (0,43,0), (1,1,0), (0,127,0) in order.
  - underflow_count=1.
- Push 9'h181 (128-255) and 9'h101 (0-255) -> pops return (1,127,0) then (1,255,0); underflow_count increments by 2.
- FULL with a 5th in_valid=1 -> the entry is dropped and in_ready=0. Pop one entry -> in_ready=1 the next cycle; the held 5th entry is accepted and appears last.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 cycles with alternating 9'h001/9'h1FF.
  - One result per cycle after the first; no loss, correct order.
  - Count stays at 1 after the first push.
- Saturation and mid-operation reset, with CW=2:
  - Push 5 negatives -> underflow_count sticks at 3.
  - Assert rst with 2 entries queued -> next cycle out_valid=0, count=0, underflow_count=0.
